// File: rtl/block_mem_responder.sv
// Block memory responder. It accepts one 64-bit block read or write at a time
// and completes it after LATENCY cycles with a one-cycle rdy strobe.
// Define BMEM_CONFLICT_ERR_EN to add the sticky conflict_err output, which
// flags a request where re and we are both high at acceptance.
module block_mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [63:0] wrt_data,
  output logic [63:0] rd_data,
  output logic        rdy
`ifdef BMEM_CONFLICT_ERR_EN
  ,
  output logic        conflict_err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_idx;
  logic [63:0]   lat_data;
  logic          lat_we;
  logic          accept, held, complete;

  logic [63:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    held      = lat_we ? we : re;
    case (state)
      IDLE: if (re || we) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (!held) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rdy = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 4'd0;
      lat_idx  <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (accept) begin
        cnt      <= CNT_LOAD;
        lat_idx  <= addr[AW-1:0];
        lat_data <= wrt_data;
        lat_we   <= we;
      end else if (state == BUSY && held && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (complete && !lat_we) rd_data <= mem[lat_idx];
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (complete && lat_we) mem[lat_idx] <= lat_data;
  end

`ifdef BMEM_CONFLICT_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    conflict_err <= 1'b0;
    else if (accept && re && we)   conflict_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed self-checking bench for block_mem_responder: one LATENCY=4 default
// instance and one LATENCY=1, DEPTH=16 instance for fast-path and wrap cases.
module tb_block_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] addr;
  logic        re, we;
  logic [63:0] wrt_data, rd_data;
  logic        rdy;
  logic [13:0] b_addr;
  logic        b_re, b_we;
  logic [63:0] b_wdata, b_rd_data;
  logic        b_rdy;
`ifdef BMEM_CONFLICT_ERR_EN
  logic        conflict_err, b_conflict_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  block_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we),
    .wrt_data(wrt_data), .rd_data(rd_data), .rdy(rdy)
`ifdef BMEM_CONFLICT_ERR_EN
    , .conflict_err(conflict_err)
`endif
  );

  block_mem_responder #(.LATENCY(1), .DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr(b_addr), .re(b_re), .we(b_we),
    .wrt_data(b_wdata), .rd_data(b_rd_data), .rdy(b_rdy)
`ifdef BMEM_CONFLICT_ERR_EN
    , .conflict_err(b_conflict_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until rdy (bounded), then drop it; lat counts edges
  // from the accepting edge through the edge that raised rdy.
  task automatic do_op(input logic r, input logic w, input logic [13:0] a,
                       input logic [63:0] d, output int lat);
    re = r; we = w; addr = a; wrt_data = d; lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rdy) begin
        lat = i;
        break;
      end
    end
    re = 1'b0; we = 1'b0;
    tick();
    check("rdy_one_cycle", 64'(rdy), 64'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] mask;

    rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wrt_data = '0;
    b_re = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", 64'(rdy), 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
`ifdef BMEM_CONFLICT_ERR_EN
    check("reset_conflict", 64'(conflict_err), 64'd0);
`endif
    rst_n = 1'b1;

    // Write then read back block 5; acceptance on first edge after reset.
    do_op(1'b0, 1'b1, 14'h0005, 64'h1111_2222_3333_4444, lat);
    check("wr5_latency", 64'(lat), 64'd5);
    check("wr5_rd_data_held", rd_data, 64'd0);
    do_op(1'b1, 1'b0, 14'h0005, 64'h0, lat);
    check("rd5_latency", 64'(lat), 64'd5);
    check("rd5_data", rd_data, 64'h1111_2222_3333_4444);

    // Held read: rdy every 6 cycles, never back to back.
    re = 1'b1; addr = 14'h0005; mask = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      mask[i] = rdy;
    end
    re = 1'b0;
    check("held_re_rdy_pattern", 64'(mask), 64'h0002_0820);
    repeat (2) tick();

    // Abort: write to 9 dropped after 2 cycles leaves block 9 and rd_data alone.
    do_op(1'b0, 1'b1, 14'h0009, 64'h9999_0000_9999_0000, lat);
    check("wr9_latency", 64'(lat), 64'd5);
    do_op(1'b1, 1'b0, 14'h0005, 64'h0, lat);
    we = 1'b1; addr = 14'h0009; wrt_data = 64'hDEAD_BEEF_DEAD_BEEF;
    mask = '0;
    repeat (3) tick();
    we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      mask[i] = rdy;
    end
    check("abort_no_rdy", 64'(mask), 64'd0);
    check("abort_rd_data_held", rd_data, 64'h1111_2222_3333_4444);
    do_op(1'b1, 1'b0, 14'h0009, 64'h0, lat);
    check("rd9_after_abort", rd_data, 64'h9999_0000_9999_0000);

    // Latched address/data: changes after acceptance are ignored.
    do_op(1'b0, 1'b1, 14'h0008, 64'h8888_8888_8888_8888, lat);
    we = 1'b1; addr = 14'h0007; wrt_data = 64'h7777_7777_7777_7777;
    tick();
    addr = 14'h0008; wrt_data = 64'h0BAD_0BAD_0BAD_0BAD;
    mask = '0;
    for (int i = 0; i < 10 && mask[0] == 1'b0; i++) begin
      tick();
      mask[0] = rdy;
    end
    we = 1'b0;
    tick();
    check("latched_wr_rdy", 64'(mask[0]), 64'd1);
    do_op(1'b1, 1'b0, 14'h0007, 64'h0, lat);
    check("rd7_latched", rd_data, 64'h7777_7777_7777_7777);
    do_op(1'b1, 1'b0, 14'h0008, 64'h0, lat);
    check("rd8_untouched", rd_data, 64'h8888_8888_8888_8888);

    // re and we together: write wins.
    do_op(1'b1, 1'b1, 14'h0003, 64'hAAAA_AAAA_AAAA_AAAA, lat);
    check("both_latency", 64'(lat), 64'd5);
    do_op(1'b1, 1'b0, 14'h0003, 64'h0, lat);
    check("rd3_write_priority", rd_data, 64'hAAAA_AAAA_AAAA_AAAA);
`ifdef BMEM_CONFLICT_ERR_EN
    check("conflict_sticky", 64'(conflict_err), 64'd1);
`endif

    // Reset mid-BUSY abandons the write to 0x10.
    do_op(1'b0, 1'b1, 14'h0010, 64'h1010_1010_1010_1010, lat);
    do_op(1'b1, 1'b0, 14'h0005, 64'h0, lat);
    we = 1'b1; addr = 14'h0010; wrt_data = 64'h5555_5555_5555_5555;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy_rdy", 64'(rdy), 64'd0);
    check("rst_busy_rd_data", rd_data, 64'd0);
`ifdef BMEM_CONFLICT_ERR_EN
    check("rst_conflict_clear", 64'(conflict_err), 64'd0);
`endif
    we = 1'b0;
    tick();
    rst_n = 1'b1;
    do_op(1'b1, 1'b0, 14'h0010, 64'h0, lat);
    check("rd10_after_reset_lat", 64'(lat), 64'd5);
    check("rd10_unmodified", rd_data, 64'h1010_1010_1010_1010);

    // LATENCY=1, DEPTH=16: rdy the cycle after acceptance, address wraps.
    b_we = 1'b1; b_addr = 14'h0015; b_wdata = 64'hB0B0_1234_5678_B0B0;
    tick();
    check("b_wr_busy", 64'(b_rdy), 64'd0);
    tick();
    check("b_wr_rdy", 64'(b_rdy), 64'd1);
    b_we = 1'b0;
    tick();
    check("b_wr_rdy_drop", 64'(b_rdy), 64'd0);
    b_re = 1'b1; b_addr = 14'h0005;
    repeat (2) tick();
    check("b_rd_rdy", 64'(b_rdy), 64'd1);
    check("b_rd_wrap", b_rd_data, 64'hB0B0_1234_5678_B0B0);
    b_re = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
